// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: opcodes, size codes, FSM states
// and store lane helpers.
package load_store_unit_pkg;

    localparam logic [4:0] OPC_LOAD  = 5'b00000;
    localparam logic [4:0] OPC_STORE = 5'b01000;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10
    } lsu_state_e;

    function automatic logic [3:0] store_strobe(input logic [2:0] func3, input logic [1:0] off);
        logic [3:0] strb;
        case (func3[1:0])
            SZ_BYTE: strb = 4'b0001 << off;
            SZ_HALF: strb = 4'b0011 << {off[1], 1'b0};
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] func3, input logic [31:0] rs2);
        logic [31:0] lanes;
        case (func3[1:0])
            SZ_BYTE: lanes = {4{rs2[7:0]}};
            SZ_HALF: lanes = {2{rs2[15:0]}};
            default: lanes = rs2;
        endcase
        return lanes;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] func3, input logic [1:0] off);
        logic bad;
        case (func3[1:0])
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            default: bad = (off != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Combinational load lane extraction with sign/zero extension (lsu_load_align).
module lsu_load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  func3,
    output logic [31:0] load_data
);

    logic [31:0] shifted_s;

    // select the addressed lane, then extend according to func3[2]
    always_comb begin
        shifted_s = rdata;
        load_data = rdata;
        case (func3[1:0])
            SZ_BYTE: begin
                shifted_s = rdata >> {addr, 3'b000};
                load_data = func3[2] ? {24'h000000, shifted_s[7:0]}
                                     : {{24{shifted_s[7]}}, shifted_s[7:0]};
            end
            SZ_HALF: begin
                shifted_s = rdata >> {addr[1], 4'b0000};
                load_data = func3[2] ? {16'h0000, shifted_s[15:0]}
                                     : {{16{shifted_s[15]}}, shifted_s[15:0]};
            end
            default: begin
                shifted_s = rdata;
                load_data = rdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one outstanding request, req/gnt + rvalid handshake.
// Optional LSU_MISALIGN_TRAP_EN adds lsu_misalign / lsu_bad_addr trap outputs.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [4:0]      ex_opcode,
    input  logic [2:0]      ex_func3,
    input  logic [XLEN-1:0] ex_addr,
    input  logic [XLEN-1:0] ex_wdata,
    input  logic [4:0]      ex_rd,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_wstrb,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            lsu_busy
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic            lsu_misalign,
    output logic [XLEN-1:0] lsu_bad_addr
`endif
);

    lsu_state_e  state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  func3_q, func3_d;
    logic [4:0]  rd_q, rd_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        is_store_s;
    logic        accept_s;
    logic [31:0] align_data_s;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign_q, misalign_d;
    logic [31:0] bad_addr_q, bad_addr_d;
`endif

    lsu_load_align u_load_align (
        .rdata     (mem_rdata),
        .addr      (off_q),
        .func3     (func3_q),
        .load_data (align_data_s)
    );

    assign is_store_s = (ex_opcode == OPC_STORE);
    assign accept_s   = ex_valid && (state_q == ST_IDLE)
                        && ((ex_opcode == OPC_LOAD) || is_store_s);

    // next-state and next-output computation
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;
        off_d       = off_q;
        func3_d     = func3_q;
        rd_d        = rd_q;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_d  = 1'b0;
        bad_addr_d  = 32'h0000_0000;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    if (is_misaligned(ex_func3, ex_addr[1:0])) begin
                        misalign_d = 1'b1;
                        bad_addr_d = ex_addr;
                    end else begin
`else
                    begin
`endif
                        state_d     = ST_REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store_s;
                        mem_addr_d  = {ex_addr[31:2], 2'b00};
                        mem_wstrb_d = is_store_s ? store_strobe(ex_func3, ex_addr[1:0]) : 4'b0000;
                        mem_wdata_d = is_store_s ? store_lanes(ex_func3, ex_wdata) : 32'h0000_0000;
                        off_d       = ex_addr[1:0];
                        func3_d     = ex_func3;
                        rd_d        = ex_rd;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    state_d     = mem_we_q ? ST_IDLE : ST_WAIT;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = 32'h0000_0000;
                    mem_wstrb_d = 4'b0000;
                    mem_wdata_d = 32'h0000_0000;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                // rvalid only counts here, so stale responses elsewhere are dropped
                if (mem_rvalid) begin
                    state_d    = ST_IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = align_data_s;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                mem_req_d   = 1'b0;
                mem_we_d    = 1'b0;
                mem_addr_d  = 32'h0000_0000;
                mem_wstrb_d = 4'b0000;
                mem_wdata_d = 32'h0000_0000;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_wstrb_q <= 4'b0000;
            mem_wdata_q <= 32'h0000_0000;
            off_q       <= 2'b00;
            func3_q     <= 3'b000;
            rd_q        <= 5'd0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= 32'h0000_0000;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
            bad_addr_q  <= 32'h0000_0000;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
            off_q       <= off_d;
            func3_q     <= func3_d;
            rd_q        <= rd_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q  <= misalign_d;
            bad_addr_q  <= bad_addr_d;
`endif
        end
    end

    assign ex_ready  = (state_q == ST_IDLE);
    assign lsu_busy  = (state_q != ST_IDLE);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wstrb = mem_wstrb_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign lsu_misalign = misalign_q;
    assign lsu_bad_addr = bad_addr_q;
`endif

endmodule
